// File: rtl/mem_bus_arbiter_if.sv
// Bundles the per-channel cache buses and the downstream memory bus handled by mem_bus_arbiter.
// The slave modport is the arbiter side; the master modport is the caches/memory side.
interface mem_bus_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    localparam int RQW = 2 + AW + DW;
    localparam int RSW = 1 + DW;

    logic [NCH*RQW-1:0] ch_bus_in;
    logic [NCH*RSW-1:0] ch_bus_out;
    logic [NCH-1:0]     ch_err;
    logic [RQW-1:0]     mem_bus_out;
    logic [RSW-1:0]     mem_bus_in;
    logic [NCH-1:0]     grant;
    logic               busy;

    modport slave (
        input  ch_bus_in, mem_bus_in,
        output ch_bus_out, ch_err, mem_bus_out, grant, busy
    );

    modport master (
        output ch_bus_in, mem_bus_in,
        input  ch_bus_out, ch_err, mem_bus_out, grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter merging NCH cache-side request buses onto one memory bus,
// with a per-transaction ack timeout that completes the transaction with an error flag.
module mem_bus_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int RQW = 2 + AW + DW;
    localparam int RSW = 1 + DW;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gidx_q;
    logic [NCH-1:0]  grant_q;
    logic [NCH-1:0]  mask_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;

    logic [NCH-1:0]  req_vec;
    logic [NCH-1:0]  eligible;
    logic            found;
    logic [IW-1:0]   sel_idx;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;
    logic            timeout_hit;

    assign mem_ack     = bus.mem_bus_in[RSW-1];
    assign mem_rdata   = bus.mem_bus_in[DW-1:0];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            req_vec[i] = bus.ch_bus_in[i*RQW + RQW - 1];
        end
    end

    // Search starts at the pointer and wraps; both loops unroll so every index is constant.
    always_comb begin
        eligible = req_vec & ~mask_q;
        found    = 1'b0;
        sel_idx  = '0;
        for (int p = 0; p < NCH; p++) begin
            if (ptr_q == IW'(p)) begin
                for (int k = 0; k < NCH; k++) begin
                    if (!found && eligible[(p + k) % NCH]) begin
                        found   = 1'b1;
                        sel_idx = IW'((p + k) % NCH);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_we    = bus.ch_bus_in[i*RQW + AW + DW];
                sel_addr  = bus.ch_bus_in[i*RQW + DW +: AW];
                sel_wdata = bus.ch_bus_in[i*RQW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_bus_out = '0;
        bus.ch_bus_out  = '0;
        bus.ch_err      = '0;
        bus.busy        = 1'b0;
        bus.grant       = grant_q;
        case (state_q)
            IDLE: begin
                if (found) state_d = WAIT;
            end
            WAIT: begin
                bus.mem_bus_out = {1'b1, we_q, addr_q, wdata_q};
                bus.busy        = 1'b1;
                if (mem_ack || timeout_hit) state_d = RESP;
            end
            RESP: begin
                bus.busy = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    if (gidx_q == IW'(i)) begin
                        bus.ch_bus_out[i*RSW +: RSW] = {1'b1, rdata_q};
                        bus.ch_err[i]                = err_q;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ack wins over timeout; the mask keeps the just-served channel out of the next IDLE decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mask_q <= '0;
                    if (found) begin
                        gidx_q  <= sel_idx;
                        grant_q <= NCH'(1) << sel_idx;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    ptr_q   <= (gidx_q == IW'(NCH - 1)) ? '0 : gidx_q + IW'(1);
                    mask_q  <= grant_q;
                    cnt_q   <= '0;
                    grant_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected responses are queued when requests are driven
// and popped when a channel ack appears; a bench memory model answers the downstream bus.
module tb_mem_bus_arbiter;
    localparam int NCH     = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;
    localparam int RQW     = 2 + AW + DW;
    localparam int RSW     = 1 + DW;

    typedef struct {
        int            ch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

    mem_bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            mem_delay = 1;
    bit            mem_stray = 0;
    int            mem_run = 0;
    int            mem_last_run = 0;
    int            mem_txn = 0;
    int            grant_bad = 0;
    logic          mem_we_seen = 1'b0;
    logic [AW-1:0] mem_addr_seen = '0;
    logic [DW-1:0] mem_wdata_seen = '0;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a ^ 32'hC0DE_0000) + 32'd7;
    endfunction

    // Memory responder: acks in the mem_delay-th cycle of a request (0 = never), 2ns after the edge.
    initial begin
        bus.mem_bus_in = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!$onehot0(bus.grant)) grant_bad++;
            if (bus.mem_bus_out[RQW-1]) begin
                mem_run++;
                if (mem_run == 1) begin
                    mem_txn++;
                    mem_we_seen    = bus.mem_bus_out[RQW-2];
                    mem_addr_seen  = bus.mem_bus_out[DW +: AW];
                    mem_wdata_seen = bus.mem_bus_out[DW-1:0];
                end
            end else begin
                if (mem_run > 0) mem_last_run = mem_run;
                mem_run = 0;
            end
            if (mem_stray)
                bus.mem_bus_in = {1'b1, 32'hBAD0BAD0};
            else if (bus.mem_bus_out[RQW-1] && mem_delay > 0 && mem_run == mem_delay)
                bus.mem_bus_in = {1'b1, mem_model(mem_addr_seen)};
            else
                bus.mem_bus_in = '0;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int ch, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ch_bus_in[ch*RQW +: RQW] = {req, we, a, d};
    endtask

    task automatic push_exp(input int ch, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic err);
        exp_t e;
        e.ch = ch; e.we = we; e.addr = a; e.wdata = d; e.err = err;
        e.rdata = err ? '0 : mem_model(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int budget, output int ch, output logic [DW-1:0] rd,
                            output logic er, output int cyc);
        ch = -1; rd = '0; er = 1'b0; cyc = 0;
        while (ch < 0 && cyc < budget) begin
            step();
            cyc++;
            for (int i = 0; i < NCH; i++) begin
                if (ch < 0 && bus.ch_bus_out[i*RSW + DW]) begin
                    ch = i;
                    rd = bus.ch_bus_out[i*RSW +: DW];
                    er = bus.ch_err[i];
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.ch_bus_in = '0;
        rst_n = 1'b0;
        step();
        set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        n_vec++;
        if (bus.busy !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++;
        if (bus.grant !== 2'b00) begin n_miss++; $display("[TB] FAIL reset_grant: got %b want 00", bus.grant); end
        n_vec++;
        if (bus.mem_bus_out !== '0) begin n_miss++; $display("[TB] FAIL reset_mem_out: got %h want 0", bus.mem_bus_out); end
        n_vec++;
        if (bus.ch_bus_out !== '0) begin n_miss++; $display("[TB] FAIL reset_ch_out: got %h want 0", bus.ch_bus_out); end
        n_vec++;
        if (bus.ch_err !== 2'b00) begin n_miss++; $display("[TB] FAIL reset_ch_err: got %b want 00", bus.ch_err); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int ch; logic [DW-1:0] rd; logic er; int cyc; exp_t e;
        mem_delay = 2;
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
        push_exp(0, 1'b0, 32'h100, 32'h0, 1'b0);
        n_vec++;
        if (bus.mem_bus_out[RQW-1] !== 1'b0) begin n_miss++; $display("[TB] FAIL single_early_req: got %b want 0", bus.mem_bus_out[RQW-1]); end
        step();
        n_vec++;
        if (bus.mem_bus_out !== {1'b1, 1'b0, 32'h100, 32'h0}) begin n_miss++; $display("[TB] FAIL single_mem_out: got %h want %h", bus.mem_bus_out, {1'b1, 1'b0, 32'h100, 32'h0}); end
        n_vec++;
        if (bus.grant !== 2'b01) begin n_miss++; $display("[TB] FAIL single_grant: got %b want 01", bus.grant); end
        wait_ack(10, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL single_resp: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        n_vec++;
        if (cyc !== 2) begin n_miss++; $display("[TB] FAIL single_latency: got %0d want 2", cyc); end
        n_vec++;
        if (bus.grant !== 2'b01) begin n_miss++; $display("[TB] FAIL single_grant_resp: got %b want 01", bus.grant); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_vec++;
        if ({bus.ch_bus_out, bus.ch_err, bus.grant} !== '0) begin n_miss++; $display("[TB] FAIL single_ack_pulse: got out=%h err=%b grant=%b want all 0", bus.ch_bus_out, bus.ch_err, bus.grant); end
    endtask

    task automatic test_round_robin();
        int ch; logic [DW-1:0] rd; logic er; int cyc; exp_t e;
        int txn0, bad0;
        do_reset();
        mem_delay = 1;
        txn0 = mem_txn;
        bad0 = grant_bad;
        set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'h300, 32'h1111_0001);
        push_exp(0, 1'b0, 32'h200, 32'h0, 1'b0);
        push_exp(1, 1'b1, 32'h300, 32'h1111_0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_ack(10, ch, rd, er, cyc);
            e = exp_q.pop_front();
            n_vec++;
            if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL rr_resp%0d: got ch%0d %h err=%b want ch%0d %h err=%b", i, ch, rd, er, e.ch, e.rdata, e.err); end
            n_vec++;
            if ({mem_we_seen, mem_addr_seen, mem_wdata_seen} !== {e.we, e.addr, e.wdata}) begin n_miss++; $display("[TB] FAIL rr_memreq%0d: got we=%b %h %h want we=%b %h %h", i, mem_we_seen, mem_addr_seen, mem_wdata_seen, e.we, e.addr, e.wdata); end
            if (ch >= 0) set_req(ch, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
            if (i < 2 && ch >= 0) begin
                set_req(ch, 1'b1, 1'b0, 32'h210 + 32'(i) * 32'h100, 32'h0);
                push_exp(ch, 1'b0, 32'h210 + 32'(i) * 32'h100, 32'h0, 1'b0);
            end
        end
        n_vec++;
        if (mem_txn - txn0 !== 4) begin n_miss++; $display("[TB] FAIL rr_txn_count: got %0d want 4", mem_txn - txn0); end
        n_vec++;
        if (grant_bad - bad0 !== 0) begin n_miss++; $display("[TB] FAIL rr_grant_onehot: got %0d bad cycles want 0", grant_bad - bad0); end
    endtask

    task automatic test_back_to_back();
        int ch; logic [DW-1:0] rd; logic er; int cyc; exp_t e;
        int txn0;
        mem_delay = 1;
        txn0 = mem_txn;
        set_req(1, 1'b1, 1'b0, 32'h700, 32'h0);
        push_exp(1, 1'b0, 32'h700, 32'h0, 1'b0);
        wait_ack(10, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL b2b_resp_a: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        step();
        n_vec++;
        if ({bus.grant, bus.busy} !== 3'b000) begin n_miss++; $display("[TB] FAIL b2b_masked: got grant=%b busy=%b want 00/0", bus.grant, bus.busy); end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        n_vec++;
        if ({bus.grant, bus.busy} !== 3'b000) begin n_miss++; $display("[TB] FAIL b2b_no_regrant: got grant=%b busy=%b want 00/0", bus.grant, bus.busy); end
        n_vec++;
        if (mem_txn - txn0 !== 1) begin n_miss++; $display("[TB] FAIL b2b_dup_txn: got %0d want 1", mem_txn - txn0); end

        set_req(1, 1'b1, 1'b1, 32'h710, 32'hCAFE_0710);
        push_exp(1, 1'b1, 32'h710, 32'hCAFE_0710, 1'b0);
        wait_ack(10, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL b2b_resp_b: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        push_exp(1, 1'b1, 32'h710, 32'hCAFE_0710, 1'b0);
        step();
        n_vec++;
        if (bus.grant !== 2'b00) begin n_miss++; $display("[TB] FAIL b2b_masked_hold: got %b want 00", bus.grant); end
        step();
        step();
        n_vec++;
        if (bus.grant !== 2'b10) begin n_miss++; $display("[TB] FAIL b2b_regrant: got %b want 10", bus.grant); end
        wait_ack(10, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL b2b_resp_c: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        n_vec++;
        if ({mem_we_seen, mem_addr_seen, mem_wdata_seen} !== {e.we, e.addr, e.wdata}) begin n_miss++; $display("[TB] FAIL b2b_memreq: got we=%b %h %h want we=%b %h %h", mem_we_seen, mem_addr_seen, mem_wdata_seen, e.we, e.addr, e.wdata); end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_vec++;
        if (mem_txn - txn0 !== 3) begin n_miss++; $display("[TB] FAIL b2b_txn_total: got %0d want 3", mem_txn - txn0); end
    endtask

    task automatic test_timeout();
        int ch; logic [DW-1:0] rd; logic er; int cyc; exp_t e;
        mem_delay = 0;
        set_req(0, 1'b1, 1'b1, 32'h400, 32'h1234_5678);
        set_req(1, 1'b1, 1'b0, 32'h480, 32'h0);
        push_exp(0, 1'b1, 32'h400, 32'h1234_5678, 1'b1);
        push_exp(1, 1'b0, 32'h480, 32'h0, 1'b0);
        wait_ack(12, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL to_resp: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        n_vec++;
        if (cyc !== 5) begin n_miss++; $display("[TB] FAIL to_latency: got %0d want 5", cyc); end
        n_vec++;
        if (bus.ch_err !== 2'b01) begin n_miss++; $display("[TB] FAIL to_err_vec: got %b want 01", bus.ch_err); end
        n_vec++;
        if ({mem_we_seen, mem_addr_seen, mem_wdata_seen} !== {e.we, e.addr, e.wdata}) begin n_miss++; $display("[TB] FAIL to_memreq: got we=%b %h %h want we=%b %h %h", mem_we_seen, mem_addr_seen, mem_wdata_seen, e.we, e.addr, e.wdata); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_delay = 1;
        step();
        n_vec++;
        if (mem_last_run !== 4) begin n_miss++; $display("[TB] FAIL to_req_cycles: got %0d want 4", mem_last_run); end
        wait_ack(10, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL to_next_resp: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_ack_timeout_collision();
        int ch; logic [DW-1:0] rd; logic er; int cyc; exp_t e;
        mem_delay = 4;
        set_req(0, 1'b1, 1'b0, 32'h500, 32'h0);
        push_exp(0, 1'b0, 32'h500, 32'h0, 1'b0);
        wait_ack(12, ch, rd, er, cyc);
        e = exp_q.pop_front();
        n_vec++;
        if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL coll_resp: got ch%0d %h err=%b want ch%0d %h err=%b", ch, rd, er, e.ch, e.rdata, e.err); end
        n_vec++;
        if (cyc !== 5) begin n_miss++; $display("[TB] FAIL coll_latency: got %0d want 5", cyc); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid_wait();
        int ch; logic [DW-1:0] rd; logic er; int cyc; exp_t e;
        mem_delay = 0;
        set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
        step();
        step();
        n_vec++;
        if (bus.mem_bus_out[RQW-1] !== 1'b1) begin n_miss++; $display("[TB] FAIL rst_pre_wait: got %b want 1", bus.mem_bus_out[RQW-1]); end
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_vec++;
        if ({bus.mem_bus_out, bus.grant, bus.busy} !== '0) begin n_miss++; $display("[TB] FAIL rst_async_outs: got mem=%h grant=%b busy=%b want all 0", bus.mem_bus_out, bus.grant, bus.busy); end
        n_vec++;
        if ({bus.ch_bus_out, bus.ch_err} !== '0) begin n_miss++; $display("[TB] FAIL rst_async_ch: got out=%h err=%b want all 0", bus.ch_bus_out, bus.ch_err); end
        step();
        rst_n = 1'b1;
        mem_stray = 1'b1;
        step();
        step();
        n_vec++;
        if ({bus.ch_bus_out, bus.busy, bus.grant} !== '0) begin n_miss++; $display("[TB] FAIL rst_stray_ack: got out=%h busy=%b grant=%b want all 0", bus.ch_bus_out, bus.busy, bus.grant); end
        mem_stray = 1'b0;
        mem_delay = 1;
        step();
        set_req(0, 1'b1, 1'b0, 32'h640, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h680, 32'h0);
        push_exp(0, 1'b0, 32'h640, 32'h0, 1'b0);
        push_exp(1, 1'b0, 32'h680, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_ack(10, ch, rd, er, cyc);
            e = exp_q.pop_front();
            n_vec++;
            if ({ch, rd, er} !== {e.ch, e.rdata, e.err}) begin n_miss++; $display("[TB] FAIL rst_after_resp%0d: got ch%0d %h err=%b want ch%0d %h err=%b", i, ch, rd, er, e.ch, e.rdata, e.err); end
            if (ch >= 0) set_req(ch, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        step();
    endtask

    initial begin
        bus.ch_bus_in = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_ack_timeout_collision();
        test_reset_mid_wait();
        n_vec++;
        if (exp_q.size() !== 0) begin n_miss++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        n_vec++;
        if (grant_bad !== 0) begin n_miss++; $display("[TB] FAIL grant_onehot: got %0d bad cycles want 0", grant_bad); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
